// File: rtl/cla_mult_seq_if.sv
// Bus between the ALU control, the sequential multiplier and the shared CLA adder.
// The slave side is the multiplier; the master side is the ALU control plus adder.
interface cla_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    modport slave (
        input  start, a, b, add_sum, add_cout,
        output busy, done, hi, lo, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, add_sum, add_cout,
        input  busy, done, hi, lo, add_a, add_b, add_cin
    );
endinterface

// File: rtl/cla_mult_seq.sv
// Unsigned shift-and-add multiplier (MULTU) that time-shares one external WIDTH-bit
// adder for WIDTH steps and returns the 2*WIDTH-bit product as hi/lo.
module cla_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_mult_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;

    // A new request is only taken when no operation is in flight.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == LAST_STEP) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= bus.a;
                r_lo  <= bus.b;
                r_hi  <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                // Adder carry becomes the new MSB; the consumed multiplier bit drops off lo.
                {r_hi, r_lo} <= {bus.add_cout, bus.add_sum, r_lo[WIDTH-1:1]};
                r_cnt        <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.add_a   = r_hi;
    assign bus.add_b   = r_lo[0] ? r_a : '0;
    assign bus.add_cin = 1'b0;
endmodule

// File: tb/tb_cla_mult_seq.sv
// Directed bench for cla_mult_seq: models the shared adder, queues expected products
// at each accepted start and compares them when done rises.
module tb_cla_mult_seq;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [2*W-1:0] sb[$];

    cla_mult_seq_if #(.WIDTH(W)) bus ();

    cla_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared carry-lookahead adder: purely combinational.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx;
        logic [2*W-1:0] yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Drive a start for one edge and queue its expected product.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit keep_start);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        sb.push_back(model(ta, tb_v));
        step();
        bus.start = keep_start;
    endtask

    // Wait (bounded) for done, then check timing and pop/compare the result.
    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        int bc;
        logic [2*W-1:0] exp;
        cyc = 0;
        bc  = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) bc++;
            step();
            cyc++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_cyc));
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_hi"}, 32'(bus.hi), 32'(exp[2*W-1:W]));
        check({tag, "_lo"}, 32'(bus.lo), 32'(exp[W-1:0]));
        $display("op %s: cycles=%0d hi=%h lo=%h", tag, cyc, bus.hi, bus.lo);
    endtask

    initial begin
        int dcount;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", 32'(bus.hi), 32'd0);
        check("rst_lo", 32'(bus.lo), 32'd0);
        check("rst_add_a", 32'(bus.add_a), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        check("rst_add_cin", 32'(bus.add_cin), 32'd0);
        rst_n = 1'b1;
        step();

        launch(16'd3, 16'd5, 1'b0);
        check("small_busy_first", 32'(bus.busy), 32'd1);
        wait_done("small", 16);
        step();
        check("small_done_pulse", 32'(bus.done), 32'd0);
        check("small_hold_hi", 32'(bus.hi), 32'h0000);
        check("small_hold_lo", 32'(bus.lo), 32'h000F);

        launch(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done("max", 16);
        step();

        launch(16'h1234, 16'h0000, 1'b0);
        wait_done("b_zero", 16);
        step();
        launch(16'h0000, 16'hABCD, 1'b0);
        wait_done("a_zero", 16);
        step();

        // Start pulse with new operands at RUN cycle 5 must be ignored.
        launch(16'h00A5, 16'h0123, 1'b0);
        repeat (4) step();
        bus.start = 1'b1;
        bus.a     = 16'h7777;
        bus.b     = 16'h8888;
        step();
        bus.start = 1'b0;
        wait_done("ignore_mid", 11);
        step();
        check("ignore_idle", 32'(bus.busy), 32'd0);

        // Start held high through RUN and DONE: back-to-back operations.
        launch(16'h00FF, 16'h0101, 1'b1);
        bus.a = 16'hBEEF;
        bus.b = 16'hCAFE;
        wait_done("b2b_first", 16);
        sb.push_back(model(16'hBEEF, 16'hCAFE));
        step();
        bus.start = 1'b0;
        check("b2b_no_gap", 32'(bus.busy), 32'd1);
        wait_done("b2b_second", 16);
        step();
        check("b2b_end_done", 32'(bus.done), 32'd0);
        check("b2b_end_busy", 32'(bus.busy), 32'd0);

        // Reset at RUN cycle 8 aborts without a done pulse.
        launch(16'h1234, 16'h5678, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_hi", 32'(bus.hi), 32'd0);
        check("abort_lo", 32'(bus.lo), 32'd0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dcount++;
            step();
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        launch(16'd7, 16'd9, 1'b0);
        wait_done("after_reset", 16);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
